// File: rtl/line_follower_pkg.sv
// Shared encodings and sensor classification for the line follower controller.
// The classifier is pure combinational logic with no state and no handshake.
package line_follower_pkg;

    typedef enum logic [2:0] {
        CMD_STOP       = 3'd0,
        CMD_FWD        = 3'd1,
        CMD_LEFT       = 3'd2,
        CMD_RIGHT      = 3'd3,
        CMD_HARD_LEFT  = 3'd4,
        CMD_HARD_RIGHT = 3'd5
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FOLLOW = 3'd1,
        ST_SEARCH = 3'd2,
        ST_LOST   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CL_END,
        CL_NONE,
        CL_HARD_LEFT,
        CL_HARD_RIGHT,
        CL_HOLD,
        CL_FWD,
        CL_LEFT,
        CL_RIGHT
    } cls_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [4:0] PAT_END  = 5'b11111;
    localparam logic [4:0] PAT_NONE = 5'b00000;

    // Bit order is {L, LC, C, RC, R}; the first matching rule wins.
    function automatic cls_e classify(input logic [4:0] f);
        logic l, lc, c, rc, r;
        cls_e res;
        {l, lc, c, rc, r} = f;
        res = CL_HOLD;
        if (f == PAT_END)            res = CL_END;
        else if (f == PAT_NONE)      res = CL_NONE;
        else if (l && !r)            res = CL_HARD_LEFT;
        else if (r && !l)            res = CL_HARD_RIGHT;
        else if (l && r)             res = CL_HOLD;
        else if (c && (lc == rc))    res = CL_FWD;
        else if (lc && !rc)          res = CL_LEFT;
        else if (rc && !lc)          res = CL_RIGHT;
        return res;
    endfunction

endpackage

// File: rtl/ir_debounce.sv
// 2-flop synchroniser plus stable-count filter; raw-to-filt latency DEBOUNCE_CYCLES+2.
// No backpressure; upd pulses for one cycle alongside each new filtered value.
module ir_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] raw,
    output logic [4:0] filt,
    output logic       upd
);
    localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [4:0]    sync1, sync2, cand;
    logic [CW-1:0] cnt;

    // cnt holds how many consecutive samples have matched cand, including the one
    // that loaded it, and saturates once the candidate has been accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            cnt   <= '0;
            filt  <= '0;
            upd   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            upd   <= 1'b0;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= CNT_ONE;
                if (CNT_MAX == CNT_ONE && sync2 != filt) begin
                    filt <= sync2;
                    upd  <= 1'b1;
                end
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
                if (cnt + CNT_ONE == CNT_MAX && cand != filt) begin
                    filt <= cand;
                    upd  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/line_follower_ctrl.sv
// Line follower: debounced IR vector -> registered motor command, one cycle after sensors_f changes.
// No backpressure; cmd_valid marks the first cycle of every new cmd value.
module line_follower_ctrl
    import line_follower_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned LOST_TIMEOUT    = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       lost_clr,
    input  logic [4:0] sensors,
    output logic [4:0] sensors_f,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic [2:0] state,
    output logic       lost
);
    localparam int unsigned   TW       = $clog2(LOST_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(LOST_TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic          f_upd;
    logic          cmd_valid_q;
    state_e        state_q, state_d;
    cmd_e          cmd_q, cmd_d, search_cmd;
    dir_e          dir_q, dir_d;
    cls_e          cls;
    logic [TW-1:0] tmo_q, tmo_d;

    ir_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (sensors),
        .filt (sensors_f),
        .upd  (f_upd)
    );

    // Sensor patterns act as events: FOLLOW/SEARCH react only when a new filtered
    // vector arrives, so a stale vector never re-triggers a transition.
    always_comb begin
        cls        = classify(sensors_f);
        search_cmd = (dir_q == DIR_LEFT) ? CMD_HARD_LEFT : CMD_HARD_RIGHT;
        state_d    = state_q;
        cmd_d      = cmd_q;
        dir_d      = dir_q;
        tmo_d      = '0;
        if (!en) begin
            state_d = ST_IDLE;
            cmd_d   = CMD_STOP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FOLLOW;
                    cmd_d   = CMD_STOP;
                end
                ST_FOLLOW, ST_SEARCH: begin
                    if (f_upd && cls != CL_NONE) begin
                        state_d = ST_FOLLOW;
                        case (cls)
                            CL_END: begin
                                state_d = ST_DONE;
                                cmd_d   = CMD_STOP;
                            end
                            CL_HARD_LEFT: begin
                                cmd_d = CMD_HARD_LEFT;
                                dir_d = DIR_LEFT;
                            end
                            CL_HARD_RIGHT: begin
                                cmd_d = CMD_HARD_RIGHT;
                                dir_d = DIR_RIGHT;
                            end
                            CL_FWD:   cmd_d = CMD_FWD;
                            CL_LEFT: begin
                                cmd_d = CMD_LEFT;
                                dir_d = DIR_LEFT;
                            end
                            CL_RIGHT: begin
                                cmd_d = CMD_RIGHT;
                                dir_d = DIR_RIGHT;
                            end
                            default: cmd_d = cmd_q;
                        endcase
                    end else if (state_q == ST_FOLLOW) begin
                        if (f_upd) begin
                            state_d = ST_SEARCH;
                            cmd_d   = search_cmd;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = ST_LOST;
                        cmd_d   = CMD_STOP;
                    end else begin
                        tmo_d = tmo_q + TMO_ONE;
                    end
                end
                ST_LOST: begin
                    cmd_d = CMD_STOP;
                    if (lost_clr) state_d = ST_IDLE;
                end
                default: cmd_d = CMD_STOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_STOP;
            dir_q       <= DIR_LEFT;
            tmo_q       <= '0;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            dir_q       <= dir_d;
            tmo_q       <= tmo_d;
            cmd_valid_q <= (cmd_d != cmd_q);
        end
    end

    assign cmd       = cmd_q;
    assign state     = state_q;
    assign lost      = (state_q == ST_LOST);
    assign cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_line_follower_ctrl.sv
// Bench for line_follower_ctrl: directed scenarios with literal expectations plus
// randomized sensor/enable/reset traffic against a behavioural model.
module tb_line_follower_ctrl;

    localparam int DB     = 4;
    localparam int LOST_T = 20;

    localparam int CLS_HOLD = -1;
    localparam int CLS_NONE = -2;
    localparam int CLS_END  = -3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       lost_clr = 1'b0;
    logic [4:0] sensors = 5'b00000;
    logic [4:0] sensors_f;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [2:0] state;
    logic       lost;

    int n_tests = 0;
    int n_fail  = 0;
    int cv_seen = 0;

    line_follower_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .LOST_TIMEOUT   (LOST_T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .lost_clr (lost_clr),
        .sensors  (sensors),
        .sensors_f(sensors_f),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .state    (state),
        .lost     (lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State numbers: 0 idle, 1 follow, 2 search, 3 lost, 4 done; dir 0 left, 1 right.
    int         m_st = 0, m_cmd = 0, m_dir = 0, m_tmo = 0, m_run = 0;
    bit         m_cv = 0, m_evt = 0;
    logic [4:0] m_p1 = '0, m_p2 = '0, m_runval = '0, m_f = '0;

    // Motor command code for a pattern, or one of the CLS_* markers.
    function automatic int model_cls(input logic [4:0] f);
        if (f == 5'b11111)          return CLS_END;
        if (f == 5'b00000)          return CLS_NONE;
        if (f[4] && !f[0])          return 4;
        if (f[0] && !f[4])          return 5;
        if (f[4] && f[0])           return CLS_HOLD;
        if (f[2] && (f[3] == f[1])) return 1;
        if (f[3] && !f[1])          return 2;
        if (f[1] && !f[3])          return 3;
        return CLS_HOLD;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cmd = 0; m_dir = 0; m_tmo = 0; m_run = 0;
        m_cv = 0; m_evt = 0;
        m_p1 = '0; m_p2 = '0; m_runval = '0; m_f = '0;
    endtask

    task automatic model_step();
        int         prev_cmd, c;
        logic [4:0] sample;
        prev_cmd = m_cmd;
        c        = model_cls(m_f);
        sample   = m_p2;
        if (!en) begin
            m_st = 0; m_cmd = 0; m_tmo = 0;
        end else if (m_st == 0) begin
            m_st = 1; m_cmd = 0;
        end else if (m_st == 1 || m_st == 2) begin
            if (m_evt && c != CLS_NONE) begin
                m_tmo = 0;
                if (c == CLS_END) begin
                    m_st = 4; m_cmd = 0;
                end else begin
                    m_st = 1;
                    if (c > 0) m_cmd = c;
                end
                if (c == 2 || c == 4) m_dir = 0;
                if (c == 3 || c == 5) m_dir = 1;
            end else if (m_st == 1) begin
                if (m_evt) begin
                    m_st = 2; m_cmd = (m_dir == 0) ? 4 : 5; m_tmo = 0;
                end
            end else begin
                m_tmo++;
                if (m_tmo >= LOST_T) begin
                    m_st = 3; m_cmd = 0; m_tmo = 0;
                end
            end
        end else if (m_st == 3) begin
            m_cmd = 0;
            if (lost_clr) m_st = 0;
        end else begin
            m_cmd = 0;
        end
        m_cv = (m_cmd != prev_cmd);
        // Front end: run length of the twice-registered sample.
        if (sample == m_runval) begin
            if (m_run < DB) m_run++;
        end else begin
            m_runval = sample;
            m_run    = 1;
        end
        m_p2  = m_p1;
        m_p1  = sensors;
        m_evt = 0;
        if (m_run >= DB && m_f != m_runval) begin
            m_f   = m_runval;
            m_evt = 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("sensors_f", int'(sensors_f), int'(m_f));
            check("cmd",       int'(cmd),       m_cmd);
            check("cmd_valid", int'(cmd_valid), int'(m_cv));
            check("state",     int'(state),     m_st);
            check("lost",      int'(lost),      int'(m_st == 3));
            if (cmd_valid) cv_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int         cv0, r, hold;
        logic [4:0] pat;

        #1;
        check("reset state",     int'(state),     0);
        check("reset cmd",       int'(cmd),       0);
        check("reset cmd_valid", int'(cmd_valid), 0);
        check("reset lost",      int'(lost),      0);
        check("reset sensors_f", int'(sensors_f), 0);
        step(3);
        rst_n = 1'b1;
        step(2);

        // Held forward pattern: accepted after DB+2 cycles, FWD one cycle later.
        cv0 = cv_seen;
        en = 1'b1; sensors = 5'b00100;
        step(1); check("en idle->follow", int'(state), 1);
        step(4); check("f before latency", int'(sensors_f), 0);
        step(1); check("f after latency", int'(sensors_f), 5'b00100);
                 check("cmd still stop", int'(cmd), 0);
        step(1); check("cmd fwd", int'(cmd), 1);
                 check("cmd_valid pulse", int'(cmd_valid), 1);
        step(1); check("cmd_valid drops", int'(cmd_valid), 0);
        step(4); check("single cv pulse", cv_seen - cv0, 1);

        // Three-cycle glitch must be filtered out.
        cv0 = cv_seen;
        sensors = 5'b11000; step(3);
        sensors = 5'b00100; step(12);
        check("glitch f", int'(sensors_f), 5'b00100);
        check("glitch cmd", int'(cmd), 1);
        check("glitch no cv", cv_seen - cv0, 0);

        // LEFT, then line lost: SEARCH left, LOST after LOST_T cycles, lost_clr.
        sensors = 5'b01100; step(7);
        check("cmd left", int'(cmd), 2);
        sensors = 5'b00000; step(7);
        check("search entered", int'(state), 2);
        check("search hard left", int'(cmd), 4);
        step(LOST_T - 1);
        check("search before timeout", int'(state), 2);
        step(1);
        check("lost state", int'(state), 3);
        check("lost flag", int'(lost), 1);
        check("lost cmd stop", int'(cmd), 0);
        lost_clr = 1'b1; step(1); lost_clr = 1'b0;
        check("lost_clr -> idle", int'(state), 0);
        check("lost flag clear", int'(lost), 0);
        step(1);
        check("idle -> follow", int'(state), 1);

        // RIGHT, search right, recover mid-search.
        sensors = 5'b00010; step(7);
        check("cmd right", int'(cmd), 3);
        sensors = 5'b00000; step(7);
        check("search right state", int'(state), 2);
        check("search hard right", int'(cmd), 5);
        step(2);
        sensors = 5'b00110; step(7);
        check("recover follow", int'(state), 1);
        check("recover cmd right", int'(cmd), 3);
        check("recover not lost", int'(lost), 0);

        // End marker, then disable.
        sensors = 5'b11111; step(7);
        check("done state", int'(state), 4);
        check("done cmd", int'(cmd), 0);
        en = 1'b0; step(1);
        check("en0 -> idle", int'(state), 0);

        // Reset in the middle of SEARCH.
        en = 1'b1; sensors = 5'b00000; step(7);
        check("pre-reset search", int'(state), 2);
        step(5);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset state",     int'(state),     0);
        check("mid reset cmd",       int'(cmd),       0);
        check("mid reset cmd_valid", int'(cmd_valid), 0);
        check("mid reset lost",      int'(lost),      0);
        check("mid reset sensors_f", int'(sensors_f), 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("post reset follow", int'(state), 1);
        check("post reset no cv", int'(cmd_valid), 0);
        step(30);
        check("no residual search", int'(state), 1);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      pat = 5'b00000;
            else if (r < 40) pat = 5'b11111;
            else             pat = 5'($urandom_range(0, 31));
            sensors = pat;
            hold = (pat == 5'b00000) ? $urandom_range(1, 40) : $urandom_range(1, 15);
            for (int j = 0; j < hold; j++) begin
                @(negedge clk);
                lost_clr = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 99) == 0) en = ~en;
                else if (!en && $urandom_range(0, 4) == 0) en = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        lost_clr = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_follower_ctrl.md
LINE_FOLLOWER_CTRL -- requirements
Module: line_follower_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000, SHALL set the stable-sample count (>=1) required before a sensor vector is accepted.
REQ-002 Parameter LOST_TIMEOUT, default 5000000, SHALL set the SEARCH duration in cycles (>=1) before declaring LOST.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state is on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port en, input, 1, SHALL be the run enable from the CPU register.
REQ-006 Port lost_clr, input, 1, SHALL be the single-cycle acknowledge that releases LOST.
REQ-007 Port sensors, input, 5, SHALL be the raw IR bits {L,LC,C,RC,R}, async to clk, 1 = line detected.
REQ-008 Port sensors_f, output, 5, SHALL be the synchronised, debounced sensor vector.
REQ-009 Port cmd, output, 3, SHALL be the motor command: 0 STOP, 1 FWD, 2 LEFT, 3 RIGHT, 4 HARD_LEFT, 5 HARD_RIGHT.
REQ-010 Port cmd_valid, output, 1, SHALL pulse for one cycle in the cycle after cmd changes value.
REQ-011 Port state, output, 3, SHALL expose the FSM state: 0 IDLE, 1 FOLLOW, 2 SEARCH, 3 LOST, 4 DONE.
REQ-012 Port lost, output, 1, SHALL be high exactly while state = LOST.

Function
REQ-013 Sensors SHALL pass through a 2-flop synchroniser before filtering.
REQ-014 Debounce: candidate register plus counter; counter clears when the synced vector differs from the candidate; when the synced vector has been equal to the candidate for DEBOUNCE_CYCLES consecutive cycles, sensors_f SHALL load the candidate. Latency from raw change, held stable, to sensors_f = DEBOUNCE_CYCLES+2 cycles.
REQ-015 Classification of f = sensors_f, first match wins: 11111 -> END; 00000 -> NONE; L&~R -> HARD_LEFT; R&~L -> HARD_RIGHT; L&R -> HOLD; C&(LC==RC) -> FWD; LC&~RC -> LEFT; RC&~LC -> RIGHT; otherwise (01010) -> HOLD.
REQ-016 cmd and state SHALL update in the cycle after sensors_f changes (1-cycle registered decode).
REQ-017 IDLE: cmd = STOP; en=1 -> FOLLOW.
REQ-018 FOLLOW: cmd = classified command; HOLD keeps previous cmd; NONE -> SEARCH; END -> DONE.
REQ-019 last_dir register: set to LEFT on LEFT/HARD_LEFT, to RIGHT on RIGHT/HARD_RIGHT; unchanged otherwise.
REQ-020 SEARCH: cmd = HARD_LEFT if last_dir = LEFT, else HARD_RIGHT; timeout counter increments every cycle; any non-NONE pattern -> FOLLOW (END -> DONE), counter cleared; counter reaching LOST_TIMEOUT -> LOST.
REQ-021 LOST: cmd = STOP; lost_clr=1 -> IDLE; sensors ignored.
REQ-022 DONE: cmd = STOP; remains until en=0.
REQ-023 en=0 in any state SHALL force IDLE next cycle, cmd = STOP, timeout counter cleared; en=0 takes priority over lost_clr and all sensor events.
REQ-024 lost_clr outside LOST SHALL be ignored.

Reset
REQ-025 On rst_n=0, immediately: state = IDLE, cmd = STOP, cmd_valid = 0, lost = 0, sensors_f = 00000, synchroniser/candidate = 00000, counters = 0, last_dir = LEFT.
REQ-026 Reset asserted mid-operation SHALL abort debounce and SEARCH with no residual count; no cmd_valid pulse on reset release.

Structure
REQ-027 Package line_follower_pkg SHALL hold cmd encodings, state encodings and the END/NONE pattern constants.
REQ-028 Sub-module ir_debounce (synchroniser + REQ-014 filter, parameterised on DEBOUNCE_CYCLES) SHALL be instantiated once.

Verification (DEBOUNCE_CYCLES=4, LOST_TIMEOUT=20)
REQ-029 en=1, sensors=00100 held -> sensors_f=00100 after 6 cycles, cmd=FWD one cycle later, single cmd_valid pulse.
REQ-030 sensors=00100 with a 3-cycle glitch to 11000 -> sensors_f and cmd unchanged, no cmd_valid.
REQ-031 sensors 01100 then 00000 held -> cmd LEFT, then SEARCH with cmd=HARD_LEFT; after 20 cycles state=LOST, lost=1, cmd=STOP; lost_clr -> IDLE.
REQ-032 SEARCH entered via 00010, then 00110 at cycle 10 -> FOLLOW, cmd=RIGHT, no LOST.
REQ-033 sensors=11111 -> DONE, cmd=STOP; en=0 -> IDLE next cycle.
REQ-034 rst_n pulsed low mid-SEARCH -> all outputs at REQ-025 values immediately; after release with en=1, state=FOLLOW.
